instruction_fetch_stage: RTL and testbench

Fetch stage between the program-counter stage and the decoding stage. Issues the current PC to instruction memory over a valid/ready request channel and tracks up to BUFFER_DEPTH in-flight fetches in order. Returned instructions are buffered and delivered through the IF/ID pipeline register (INSTRUCTION, PC_DECODING). Pipeline flushes are honoured with an epoch bit, so fetches already in flight when a redirect occurs are discarded on return.

---
 rtl/instruction_fetch_stage_if.sv | 45 ++++
 rtl/instruction_fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - fetch-stage bundle: PC input, imem request/response channel, IF/ID outputs
interface instruction_fetch_stage_if;
   logic [31:0] PC;
   logic        FETCH_STALL;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_REQ_VALID;
   logic        IMEM_REQ_READY;
   logic        IMEM_RESP_VALID;
   logic [31:0] IMEM_RESP_DATA;
   logic        STALL_DECODING_STAGE;
   logic        CLEAR_DECODING_STAGE;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC_DECODING;
   logic        INSTRUCTION_VALID;

   modport master (
      input  PC,
      input  IMEM_REQ_READY,
      input  IMEM_RESP_VALID,
      input  IMEM_RESP_DATA,
      input  STALL_DECODING_STAGE,
      input  CLEAR_DECODING_STAGE,
      output FETCH_STALL,
      output IMEM_ADDR,
      output IMEM_REQ_VALID,
      output INSTRUCTION,
      output PC_DECODING,
      output INSTRUCTION_VALID
   );

   modport slave (
      output PC,
      output IMEM_REQ_READY,
      output IMEM_RESP_VALID,
      output IMEM_RESP_DATA,
      output STALL_DECODING_STAGE,
      output CLEAR_DECODING_STAGE,
      input  FETCH_STALL,
      input  IMEM_ADDR,
      input  IMEM_REQ_VALID,
      input  INSTRUCTION,
      input  PC_DECODING,
      input  INSTRUCTION_VALID
   );
endinterface

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - in-order instruction fetch with tag FIFO, fetch buffer, epoch flush and IF/ID register
module instruction_fetch_stage #(
   parameter int unsigned BUFFER_DEPTH    = 2,
   parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
   input  logic CLK,
   input  logic RST,
   instruction_fetch_stage_if.master bus
);
   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;
   localparam int unsigned PW = $clog2(BUFFER_DEPTH);
   localparam int unsigned CW = PW + 2;
   localparam logic [CW-1:0] DEPTH_C  = CW'(BUFFER_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   typedef struct packed {
      logic [31:0] pc;
      logic        epoch;
   } tag_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fbuf_t;

   tag_t          tag_mem_q [BUFFER_DEPTH];
   tag_t          tag_mem_d [BUFFER_DEPTH];
   logic [PW-1:0] tag_wr_ptr_q, tag_wr_ptr_d;
   logic [PW-1:0] tag_rd_ptr_q, tag_rd_ptr_d;
   logic [CW-1:0] outstanding_q, outstanding_d;

   fbuf_t         buf_mem_q [BUFFER_DEPTH];
   fbuf_t         buf_mem_d [BUFFER_DEPTH];
   logic [PW-1:0] buf_wr_ptr_q, buf_wr_ptr_d;
   logic [PW-1:0] buf_rd_ptr_q, buf_rd_ptr_d;
   logic [CW-1:0] buf_count_q, buf_count_d;

   logic          epoch_q, epoch_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pc_dec_q, pc_dec_d;
   logic          valid_q, valid_d;

   logic [CW-1:0] in_use;
   logic          req_valid;
   logic          accept;
   logic          resp_fire;
   logic          resp_live;
   logic          buf_push;
   logic          buf_pop;
   tag_t          tag_head;
   fbuf_t         buf_head;

   // Slots are reserved at request time, so an accepted fetch always finds buffer room.
   always_comb begin
      in_use    = outstanding_q + buf_count_q;
      req_valid = !RST && !bus.CLEAR_DECODING_STAGE && (in_use < DEPTH_C);
      accept    = req_valid && bus.IMEM_REQ_READY;
      tag_head  = tag_mem_q[tag_rd_ptr_q];
      buf_head  = buf_mem_q[buf_rd_ptr_q];
      resp_fire = bus.IMEM_RESP_VALID && (outstanding_q != '0);
      resp_live = resp_fire && (tag_head.epoch == epoch_q) && !bus.CLEAR_DECODING_STAGE;
   end

   assign bus.IMEM_REQ_VALID    = req_valid;
   assign bus.IMEM_ADDR         = bus.PC;
   assign bus.FETCH_STALL       = !accept;
   assign bus.INSTRUCTION       = instr_q;
   assign bus.PC_DECODING       = pc_dec_q;
   assign bus.INSTRUCTION_VALID = valid_q;

   always_comb begin
      tag_mem_d     = tag_mem_q;
      tag_wr_ptr_d  = tag_wr_ptr_q;
      tag_rd_ptr_d  = tag_rd_ptr_q;
      outstanding_d = outstanding_q;
      buf_mem_d     = buf_mem_q;
      buf_wr_ptr_d  = buf_wr_ptr_q;
      buf_rd_ptr_d  = buf_rd_ptr_q;
      buf_count_d   = buf_count_q;
      epoch_d       = epoch_q;
      instr_d       = instr_q;
      pc_dec_d      = pc_dec_q;
      valid_d       = valid_q;
      buf_push      = LOW;
      buf_pop       = LOW;

      if (accept) begin
         tag_mem_d[tag_wr_ptr_q] = '{pc: bus.PC, epoch: epoch_q};
         tag_wr_ptr_d            = tag_wr_ptr_q + PTR_ONE;
      end
      if (resp_fire) begin
         tag_rd_ptr_d = tag_rd_ptr_q + PTR_ONE;
      end
      outstanding_d = outstanding_q + (accept ? CNT_ONE : '0) - (resp_fire ? CNT_ONE : '0);

      // Buffered instructions are older than any live response, so they drain first.
      if (bus.CLEAR_DECODING_STAGE) begin
         epoch_d  = !epoch_q;
         instr_d  = NOP_INSTRUCTION;
         pc_dec_d = '0;
         valid_d  = LOW;
      end else if (bus.STALL_DECODING_STAGE) begin
         buf_push = resp_live;
      end else if (buf_count_q != '0) begin
         instr_d  = buf_head.instr;
         pc_dec_d = buf_head.pc;
         valid_d  = HIGH;
         buf_pop  = HIGH;
         buf_push = resp_live;
      end else if (resp_live) begin
         instr_d  = bus.IMEM_RESP_DATA;
         pc_dec_d = tag_head.pc;
         valid_d  = HIGH;
      end else begin
         instr_d  = NOP_INSTRUCTION;
         pc_dec_d = '0;
         valid_d  = LOW;
      end

      if (buf_push) begin
         buf_mem_d[buf_wr_ptr_q] = '{pc: tag_head.pc, instr: bus.IMEM_RESP_DATA};
         buf_wr_ptr_d            = buf_wr_ptr_q + PTR_ONE;
      end
      if (buf_pop) begin
         buf_rd_ptr_d = buf_rd_ptr_q + PTR_ONE;
      end
      buf_count_d = buf_count_q + (buf_push ? CNT_ONE : '0) - (buf_pop ? CNT_ONE : '0);

      if (bus.CLEAR_DECODING_STAGE) begin
         buf_count_d  = '0;
         buf_wr_ptr_d = '0;
         buf_rd_ptr_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tag_mem_q     <= '{default: '0};
         tag_wr_ptr_q  <= '0;
         tag_rd_ptr_q  <= '0;
         outstanding_q <= '0;
         buf_mem_q     <= '{default: '0};
         buf_wr_ptr_q  <= '0;
         buf_rd_ptr_q  <= '0;
         buf_count_q   <= '0;
         epoch_q       <= LOW;
         instr_q       <= NOP_INSTRUCTION;
         pc_dec_q      <= '0;
         valid_q       <= LOW;
      end else begin
         tag_mem_q     <= tag_mem_d;
         tag_wr_ptr_q  <= tag_wr_ptr_d;
         tag_rd_ptr_q  <= tag_rd_ptr_d;
         outstanding_q <= outstanding_d;
         buf_mem_q     <= buf_mem_d;
         buf_wr_ptr_q  <= buf_wr_ptr_d;
         buf_rd_ptr_q  <= buf_rd_ptr_d;
         buf_count_q   <= buf_count_d;
         epoch_q       <= epoch_d;
         instr_q       <= instr_d;
         pc_dec_q      <= pc_dec_d;
         valid_q       <= valid_d;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench: random PC/memory/stall/flush traffic against a delivery-order model
module tb_instruction_fetch_stage;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   lat_fix = 1;
   logic [31:0] redirect_pc = '0;

   instruction_fetch_stage_if bus();

   instruction_fetch_stage #(
      .BUFFER_DEPTH(2),
      .NOP_INSTRUCTION(NOP)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Memory: in-order responses, each at least its latency after acceptance.
   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;
   resp_t mem_q[$];
   int    last_due = 0;

   always @(negedge clk) begin
      int l;
      int d;
      if (bus.IMEM_REQ_VALID === 1'b1 && bus.IMEM_REQ_READY === 1'b1) begin
         l = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
         d = cyc + l;
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         mem_q.push_back('{d, mem_word(bus.IMEM_ADDR)});
      end
   end

   initial begin
      bus.IMEM_RESP_VALID = 1'b0;
      bus.IMEM_RESP_DATA  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            bus.IMEM_RESP_VALID = 1'b1;
            bus.IMEM_RESP_DATA  = mem_q[0].data;
            void'(mem_q.pop_front());
         end else begin
            bus.IMEM_RESP_VALID = 1'b0;
            bus.IMEM_RESP_DATA  = $urandom;
         end
      end
   end

   // Reference: every accepted PC is delivered once, in order, unless a flush or reset intervenes first.
   logic [31:0] exp_pc_q[$];
   logic        m_acc = 1'b0;
   logic        m_flush = 1'b0;
   logic [31:0] m_pc = '0;

   always @(negedge clk) begin
      m_acc   = (bus.IMEM_REQ_VALID === 1'b1) && (bus.IMEM_REQ_READY === 1'b1);
      m_pc    = bus.IMEM_ADDR;
      m_flush = (rst === 1'b1) || (bus.CLEAR_DECODING_STAGE === 1'b1);
   end

   always @(posedge clk) begin
      if (m_flush) exp_pc_q.delete();
      if (m_acc) exp_pc_q.push_back(m_pc);
   end

   logic stall_prev = 1'b0;
   always @(negedge clk) begin
      logic [31:0] p;
      if (rst === 1'b0 && bus.INSTRUCTION_VALID === 1'b1 && !stall_prev) begin
         if (exp_pc_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got pc %h instr %h want nothing", bus.PC_DECODING, bus.INSTRUCTION);
         end else begin
            p = exp_pc_q.pop_front();
            check("sb_pc", bus.PC_DECODING, p);
            check("sb_instr", bus.INSTRUCTION, mem_word(p));
         end
      end
      stall_prev = (bus.STALL_DECODING_STAGE === 1'b1);
   end

   // PC stage: advance on acceptance, jump to redirect_pc after a flush cycle.
   task automatic adv();
      logic fs;
      logic clr;
      fs  = bus.FETCH_STALL;
      clr = bus.CLEAR_DECODING_STAGE;
      @(posedge clk);
      #1;
      if (clr) bus.PC = redirect_pc;
      else if (!fs) bus.PC = bus.PC + 32'd4;
      bus.CLEAR_DECODING_STAGE = 1'b0;
   endtask

   task automatic drain(input int n);
      bus.IMEM_REQ_READY = 1'b0;
      bus.STALL_DECODING_STAGE = 1'b0;
      repeat (n) begin
         @(negedge clk);
         adv();
      end
   endtask

   task automatic wait_valid(input string name, input logic [31:0] exp_pc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (bus.INSTRUCTION_VALID === 1'b1) begin
            seen = 1'b1;
            check(name, bus.PC_DECODING, exp_pc);
         end
         adv();
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s: no valid output within 30 cycles, want pc %h", name, exp_pc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr"}, bus.INSTRUCTION, NOP);
      check({tag, "_pcdec"}, bus.PC_DECODING, 32'h0);
      check({tag, "_valid"}, 32'(bus.INSTRUCTION_VALID), 32'h0);
      check({tag, "_reqv"}, 32'(bus.IMEM_REQ_VALID), 32'h0);
      check({tag, "_fstall"}, 32'(bus.FETCH_STALL), 32'h1);
   endtask

   initial begin
      rst = 1'b1;
      bus.PC = '0;
      bus.IMEM_REQ_READY = 1'b0;
      bus.STALL_DECODING_STAGE = 1'b0;
      bus.CLEAR_DECODING_STAGE = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst0");

      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.PC = 32'h0;
      bus.IMEM_REQ_READY = 1'b1;
      lat_fix = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c < 2) begin
            check("lat_valid_low", 32'(bus.INSTRUCTION_VALID), 32'h0);
         end else begin
            check("lat_valid_high", 32'(bus.INSTRUCTION_VALID), 32'h1);
            check("stream_pc", bus.PC_DECODING, 32'(4 * (c - 2)));
         end
         adv();
      end

      bus.STALL_DECODING_STAGE = 1'b1;
      for (int c = 5; c < 9; c++) begin
         @(negedge clk);
         if (c == 8) begin
            check("stall_hold_pc", bus.PC_DECODING, 32'd12);
            check("stall_hold_valid", 32'(bus.INSTRUCTION_VALID), 32'h1);
            check("stall_full_fstall", 32'(bus.FETCH_STALL), 32'h1);
         end
         adv();
      end
      bus.STALL_DECODING_STAGE = 1'b0;
      for (int c = 9; c < 13; c++) begin
         @(negedge clk);
         if (c >= 10) check("stall_release_pc", bus.PC_DECODING, 32'(4 * (c - 6)));
         adv();
      end

      bus.IMEM_REQ_READY = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("notready_fstall", 32'(bus.FETCH_STALL), 32'h1);
         check("notready_addr", bus.IMEM_ADDR, bus.PC);
         adv();
      end
      bus.IMEM_REQ_READY = 1'b1;
      repeat (4) begin
         @(negedge clk);
         adv();
      end

      drain(8);
      lat_fix = 3;
      bus.IMEM_REQ_READY = 1'b1;
      @(negedge clk);
      adv();
      @(negedge clk);
      adv();
      bus.CLEAR_DECODING_STAGE = 1'b1;
      redirect_pc = 32'h1000;
      @(negedge clk);
      adv();
      @(negedge clk);
      check("flush_valid", 32'(bus.INSTRUCTION_VALID), 32'h0);
      check("flush_nop", bus.INSTRUCTION, NOP);
      adv();
      wait_valid("flush_redirect_pc", 32'h1000);

      drain(8);
      lat_fix = 1;
      bus.IMEM_REQ_READY = 1'b1;
      @(negedge clk);
      adv();
      bus.IMEM_REQ_READY = 1'b0;
      bus.CLEAR_DECODING_STAGE = 1'b1;
      bus.STALL_DECODING_STAGE = 1'b1;
      redirect_pc = 32'h2000;
      @(negedge clk);
      adv();
      bus.STALL_DECODING_STAGE = 1'b0;
      @(negedge clk);
      check("clrstall_valid", 32'(bus.INSTRUCTION_VALID), 32'h0);
      check("clrstall_nop", bus.INSTRUCTION, NOP);
      check("clrstall_outstanding", 32'(dut.outstanding_q), 32'h0);
      adv();
      bus.IMEM_REQ_READY = 1'b1;
      wait_valid("clrstall_redirect_pc", 32'h2000);

      drain(8);
      lat_fix = 3;
      bus.STALL_DECODING_STAGE = 1'b1;
      bus.IMEM_REQ_READY = 1'b1;
      repeat (3) begin
         @(negedge clk);
         adv();
      end
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.IMEM_REQ_READY = 1'b0;
      bus.STALL_DECODING_STAGE = 1'b0;
      bus.PC = 32'h3000;
      repeat (8) begin
         @(negedge clk);
         adv();
      end
      @(negedge clk);
      check("post_rst_valid", 32'(bus.INSTRUCTION_VALID), 32'h0);
      check("post_rst_outstanding", 32'(dut.outstanding_q), 32'h0);
      adv();

      lat_fix = 0;
      for (int i = 0; i < 800; i++) begin
         bus.IMEM_REQ_READY = ($urandom_range(0, 3) != 0);
         bus.STALL_DECODING_STAGE = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 24) == 0) begin
            bus.CLEAR_DECODING_STAGE = 1'b1;
            redirect_pc = $urandom & 32'h000FFFFC;
         end
         @(negedge clk);
         adv();
      end

      bus.IMEM_REQ_READY = 1'b0;
      bus.STALL_DECODING_STAGE = 1'b0;
      for (int i = 0; i < 60 && (exp_pc_q.size() != 0 || mem_q.size() != 0); i++) begin
         @(negedge clk);
         adv();
      end
      repeat (3) begin
         @(negedge clk);
         adv();
      end
      check("drain_empty", 32'(exp_pc_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
